// File: rtl/softmax_norm_feeder.sv
// softmax_norm_feeder: buffers one row of ROW_LEN unsigned exponent values,
// accumulates their sum, then streams (exp_i, row_sum) operand pairs to the
// divider one per handshake, in element order.
//
// Build option: define SOFTMAX_ZERO_GUARD_EN to replace a zero row sum with a
// denominator of 1 and raise zero_row for that row. Without it the raw sum is
// forwarded and zero_row is tied low.
module softmax_norm_feeder #(
    parameter int WIDTH           = 8,
    parameter int FRACTIONAL_BITS = 8,
    parameter int ROW_LEN         = 4,
    parameter int IDX_W           = $clog2(ROW_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 div_valid,
    input  logic                 div_ready,
    output logic [2*WIDTH-1:0]   div_a,
    output logic [2*WIDTH-1:0]   div_b,
    output logic                 div_flag,
    output logic [IDX_W-1:0]     div_idx,
    output logic                 div_last,
    output logic                 zero_row
);

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    // FRACTIONAL_BITS only matters to the divider; it is checked here so a
    // nonsensical configuration is caught when this stage is elaborated.
    if (ROW_LEN < 2 || ROW_LEN > (1 << WIDTH) || FRACTIONAL_BITS < 0) begin : g_bad_params
        $error("softmax_norm_feeder: illegal parameter combination");
    end

    state_t             state;
    logic [WIDTH-1:0]   row_buf [ROW_LEN];
    logic [IDX_W-1:0]   wr_idx;
    logic [2*WIDTH-1:0] sum;

    logic               accept;
    logic               handshake;
    logic [2*WIDTH-1:0] sum_next;
    logic [2*WIDTH-1:0] entry_b;
    logic [IDX_W-1:0]   rd_next;

    assign accept    = in_valid & in_ready;
    assign handshake = div_valid & div_ready;
    assign sum_next  = sum + {{WIDTH{1'b0}}, in_data};
    assign rd_next   = div_idx + 1'b1;
    assign div_flag  = div_valid;

`ifdef SOFTMAX_ZERO_GUARD_EN
    logic row_zero;

    // The divider returns 0 for exp_i / 1, which is the sensible softmax
    // output for an all-zero row instead of its divide-by-zero pattern.
    assign row_zero = (sum_next == '0);
    assign entry_b  = row_zero ? {{(2*WIDTH-1){1'b0}}, 1'b1} : sum_next;
`else
    assign entry_b  = sum_next;
    assign zero_row = 1'b0;
`endif

    // Row buffer capture on every accepted exponent value.
    // NOTE: the row buffer has no reset; every entry is written during LOAD
    // before EMIT reads it, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[wr_idx] <= in_data;
        end
    end

    // Load/emit sequencer with all divider-side outputs registered.
    // NOTE: non-blocking assignments throughout, so every register here sees
    // the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            div_valid <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            div_idx   <= '0;
            div_last  <= 1'b0;
            wr_idx    <= '0;
            sum       <= '0;
`ifdef SOFTMAX_ZERO_GUARD_EN
            zero_row  <= 1'b0;
`endif
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (wr_idx == LAST_IDX) begin
                            // Final element: the first pair is ready next cycle.
                            // Entry 0 was written on an earlier accept.
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            div_valid <= 1'b1;
                            div_a     <= {{WIDTH{1'b0}}, row_buf[0]};
                            div_b     <= entry_b;
                            div_idx   <= '0;
                            div_last  <= 1'b0;
`ifdef SOFTMAX_ZERO_GUARD_EN
                            zero_row  <= row_zero;
`endif
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (div_last) begin
                            state     <= LOAD;
                            in_ready  <= 1'b1;
                            div_valid <= 1'b0;
                            div_last  <= 1'b0;
                            div_idx   <= '0;
                            wr_idx    <= '0;
                            sum       <= '0;
`ifdef SOFTMAX_ZERO_GUARD_EN
                            zero_row  <= 1'b0;
`endif
                        end else begin
                            // div_b stays put: the whole row shares one denominator.
                            div_idx  <= rd_next;
                            div_a    <= {{WIDTH{1'b0}}, row_buf[rd_next]};
                            div_last <= (rd_next == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm_feeder.sv
// Self-checking bench for softmax_norm_feeder: directed rows from the test
// plan followed by randomized rows, gaps and backpressure, all scored against
// a row-level reference model (queues of expected operand pairs).
module tb_softmax_norm_feeder;

    localparam int WIDTH   = 8;
    localparam int ROW_LEN = 4;
    localparam int IDX_W   = $clog2(ROW_LEN);

`ifdef SOFTMAX_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef logic [WIDTH-1:0] row_t [ROW_LEN];

    typedef struct {
        longint unsigned a;
        longint unsigned b;
        longint unsigned idx;
        bit              last;
        bit              zero;
    } pair_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 div_valid;
    logic                 div_ready = 1'b0;
    logic [2*WIDTH-1:0]   div_a;
    logic [2*WIDTH-1:0]   div_b;
    logic                 div_flag;
    logic [IDX_W-1:0]     div_idx;
    logic                 div_last;
    logic                 zero_row;

    int check_count = 0;
    int pass_count  = 0;

    longint unsigned row_q[$];   // values accepted for the row being loaded
    pair_t           exp_q[$];   // pairs the DUT still owes the divider

    softmax_norm_feeder #(
        .WIDTH          (WIDTH),
        .FRACTIONAL_BITS(8),
        .ROW_LEN        (ROW_LEN),
        .IDX_W          (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .div_valid(div_valid),
        .div_ready(div_ready),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_flag (div_flag),
        .div_idx  (div_idx),
        .div_last (div_last),
        .zero_row (zero_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
        check_count++;
        if (got == want) pass_count++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    // A full row becomes ROW_LEN expected pairs sharing one denominator.
    function automatic void close_row();
        longint unsigned total = 0;
        foreach (row_q[i]) total += row_q[i];
        for (int i = 0; i < ROW_LEN; i++) begin
            pair_t p;
            p.a    = row_q[i];
            p.zero = GUARD && (total == 0);
            p.b    = p.zero ? 1 : total;
            p.idx  = i;
            p.last = (i == ROW_LEN - 1);
            exp_q.push_back(p);
        end
        row_q.delete();
    endfunction

    // One clock cycle: check what the DUT shows now, drive inputs for the next
    // edge, and advance the model by whatever handshakes that edge performs.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r, output bit took);
        bit busy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        div_ready = r;
        busy = (exp_q.size() != 0);
        check("in_ready", in_ready, !busy);
        check("div_valid", div_valid, busy);
        check("div_flag", div_flag, busy);
        if (busy) begin
            check("div_a", div_a, exp_q[0].a);
            check("div_b", div_b, exp_q[0].b);
            check("div_idx", div_idx, exp_q[0].idx);
            check("div_last", div_last, exp_q[0].last);
            check("zero_row", zero_row, exp_q[0].zero);
        end else begin
            check("zero_row_idle", zero_row, 0);
        end
        took = v && !busy;
        if (busy && r) void'(exp_q.pop_front());
        if (took) begin
            row_q.push_back(d);
            if (row_q.size() == ROW_LEN) close_row();
        end
    endtask

    task automatic feed(input row_t vals, input int gap_pct, input int rdy_pct);
        for (int i = 0; i < ROW_LEN; i++) begin
            bit took = 1'b0;
            int n = 0;
            while (!took) begin
                bit r = ($urandom_range(99) < rdy_pct);
                if ($urandom_range(99) < gap_pct) step(1'b0, WIDTH'($urandom), r, took);
                else step(1'b1, vals[i], r, took);
                n++;
                if (n > 200) begin
                    check("feed_timeout", n, 0);
                    return;
                end
            end
        end
    endtask

    task automatic drain(input int rdy_pct, input bit hold_valid);
        int n = 0;
        bit took;
        while (exp_q.size() != 0) begin
            step(hold_valid, WIDTH'($urandom), ($urandom_range(99) < rdy_pct), took);
            n++;
            if (n > 500) begin
                check("drain_timeout", exp_q.size(), 0);
                exp_q.delete();
                return;
            end
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic pulse_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        div_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_div_valid", div_valid, 0);
        check("rst_div_flag", div_flag, 0);
        check("rst_div_a", div_a, 0);
        check("rst_div_b", div_b, 0);
        check("rst_div_idx", div_idx, 0);
        check("rst_div_last", div_last, 0);
        check("rst_zero_row", zero_row, 0);
        row_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        bit   took;

        pulse_reset();

        // Row with the divider always ready.
        r = '{8'd1, 8'd211, 8'd91, 8'd71};
        feed(r, 0, 100);
        for (int i = 0; i < ROW_LEN; i++) begin
            step(1'b0, '0, 1'b1, took);
            check("tp1_a", div_a, r[i]);
            check("tp1_b", div_b, 374);
        end
        step(1'b0, '0, 1'b1, took);

        // Three-cycle stall on the second pair.
        r = '{8'd16, 8'd3, 8'd255, 8'd11};
        feed(r, 0, 100);
        step(1'b0, '0, 1'b1, took);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, took);
            check("tp2_stall_a", div_a, 3);
            check("tp2_stall_b", div_b, 285);
            check("tp2_stall_idx", div_idx, 1);
        end
        drain(100, 1'b0);

        // in_valid held with changing data throughout EMIT.
        r = '{8'd7, 8'd9, 8'd200, 8'd33};
        feed(r, 0, 100);
        drain(60, 1'b1);
        r = '{8'd5, 8'd6, 8'd7, 8'd8};
        feed(r, 0, 100);
        step(1'b0, '0, 1'b1, took);
        check("tp3_first_a", div_a, 5);
        check("tp3_sum", div_b, 26);
        drain(100, 1'b0);

        // All-zero row.
        r = '{8'd0, 8'd0, 8'd0, 8'd0};
        feed(r, 0, 100);
        for (int i = 0; i < ROW_LEN; i++) begin
            step(1'b0, '0, 1'b1, took);
            check("tp4_b", div_b, GUARD ? 1 : 0);
            check("tp4_zero_row", zero_row, GUARD);
        end
        drain(100, 1'b0);

        // Reset after two accepts, then reset during EMIT at index 1.
        step(1'b1, 8'd50, 1'b1, took);
        step(1'b1, 8'd60, 1'b1, took);
        pulse_reset();
        r = '{8'd100, 8'd101, 8'd102, 8'd103};
        feed(r, 0, 100);
        step(1'b0, '0, 1'b1, took);
        step(1'b0, '0, 1'b0, took);
        check("tp5_idx_before_rst", div_idx, 1);
        pulse_reset();
        r = '{8'd255, 8'd255, 8'd255, 8'd255};
        feed(r, 0, 100);
        for (int i = 0; i < ROW_LEN; i++) begin
            step(1'b0, '0, 1'b1, took);
            check("tp5_a", div_a, 255);
            check("tp5_b", div_b, 1020);
        end
        step(1'b0, '0, 1'b1, took);

        // Back-to-back rows with no carry-over.
        r = '{8'd1, 8'd4, 8'd1, 8'd4};
        feed(r, 0, 100);
        r = '{8'd10, 8'd40, 8'd9, 8'd10};
        feed(r, 0, 100);
        step(1'b0, '0, 1'b1, took);
        check("tp6_b", div_b, 69);
        drain(100, 1'b0);

        // Randomized rows, gaps and backpressure.
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(7);
            for (int i = 0; i < ROW_LEN; i++) begin
                case (kind)
                    0:       r[i] = '0;
                    1:       r[i] = '1;
                    2:       r[i] = ($urandom_range(1) != 0) ? '1 : '0;
                    default: r[i] = WIDTH'($urandom);
                endcase
            end
            feed(r, $urandom_range(50), 30 + $urandom_range(70));
            if ($urandom_range(3) == 0) drain(30 + $urandom_range(70), $urandom_range(1) != 0);
        end
        drain(100, 1'b0);
        step(1'b0, '0, 1'b1, took);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
